// File: rtl/levenshtein_pkg.sv
// Shared widths, saturation constant and initial-hp helper for the Levenshtein engines.
package levenshtein_pkg;

  localparam int BITVECTOR_WIDTH_DEF  = 16;
  localparam int DISTANCE_WIDTH_DEF   = 8;
  localparam int LANES_DEF            = 4;
  localparam int LANE_INDEX_WIDTH_DEF = 2;

  // Wide all-ones; each user takes the low DISTANCE_WIDTH bits.
  localparam logic [31:0] DISTANCE_SATURATED = '1;

  // Bit i of the initial hp vector: one column per search-word character.
  function automatic logic init_hp_bit(input int i, input int ws);
    return i < ws;
  endfunction

endpackage

// File: rtl/levenshtein_lane.sv
// One Myers bit-vector lane: column step, distance tracking with sticky saturation.
module levenshtein_lane
  import levenshtein_pkg::*;
#(
  parameter int BITVECTOR_WIDTH = BITVECTOR_WIDTH_DEF,
  parameter int DISTANCE_WIDTH  = DISTANCE_WIDTH_DEF
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       init,
  input  logic                       step,
  input  logic [BITVECTOR_WIDTH-1:0] pm,
  input  logic [DISTANCE_WIDTH-1:0]  word_size,
  output logic [DISTANCE_WIDTH-1:0]  d,
  output logic                       en
);

  localparam int BW = BITVECTOR_WIDTH;
  localparam int DW = DISTANCE_WIDTH;
  localparam logic [DW-1:0] SAT = DISTANCE_SATURATED[DW-1:0];

  logic [BW-1:0] hp, hn, hp_init, d0, vp, vn;
  logic [DW-1:0] ws;
  logic          ovf, inc, dec;

  always_comb begin
    hp_init = '0;
    for (int i = 0; i < BW; i++) hp_init[i] = init_hp_bit(i, 32'(word_size));
  end

  assign d0 = (((pm & hp) + hp) ^ hp) | pm | hn;
  assign vp = hn | ~(d0 | hp);
  assign vn = d0 & hp;

  // Score moves with the last column of the word, selected by the latched size.
  always_comb begin
    inc = 1'b0;
    dec = 1'b0;
    for (int i = 0; i < BW; i++)
      if (ws == DW'(i + 1)) begin
        inc = vp[i];
        dec = vn[i];
      end
  end

  always_ff @(posedge aclk) begin
    if (areset || init) begin
      ws  <= word_size;
      d   <= word_size;
      hp  <= hp_init;
      hn  <= '0;
      ovf <= 1'b0;
      en  <= (word_size != '0) && (32'(word_size) <= 32'(BW));
    end else if (step && en) begin
      hp <= (vn << 1) | ~(d0 | (vp << 1) | BW'(1));
      hn <= d0 & ((vp << 1) | BW'(1));
      if (ovf) begin
        d <= SAT;
      end else if (inc && !dec) begin
        if (d == SAT) ovf <= 1'b1;
        else          d   <= d + 1'b1;
      end else if (dec && !inc) begin
        d <= d - 1'b1;
      end
    end
  end

endmodule

// File: rtl/levenshtein_multi.sv
// Multi-lane Levenshtein scorer: LANES words against one text stream, min result per text word.
// Optional macro LEVENSHTEIN_MATCH_VECTOR_EN adds the per-lane m_axis_tmatch output.
module levenshtein_multi
  import levenshtein_pkg::*;
#(
  parameter int BITVECTOR_WIDTH  = BITVECTOR_WIDTH_DEF,
  parameter int DISTANCE_WIDTH   = DISTANCE_WIDTH_DEF,
  parameter int LANES            = LANES_DEF,
  parameter int LANE_INDEX_WIDTH = LANE_INDEX_WIDTH_DEF
) (
  input  logic                                aclk,
  input  logic                                areset,
  input  logic [LANES*DISTANCE_WIDTH-1:0]     word_size,
  input  logic [DISTANCE_WIDTH-1:0]           threshold,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  input  logic [LANES*BITVECTOR_WIDTH-1:0]    s_axis_tdata,
  input  logic                                s_axis_tuser,
  input  logic                                s_axis_tlast,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic [DISTANCE_WIDTH-1:0]           m_axis_tdata,
  output logic [LANE_INDEX_WIDTH-1:0]         m_axis_tid,
  output logic                                m_axis_tuser,
  output logic                                m_axis_tlast
`ifdef LEVENSHTEIN_MATCH_VECTOR_EN
  ,
  output logic [LANES-1:0]                    m_axis_tmatch
`endif
);

  localparam int DW = DISTANCE_WIDTH;
  localparam logic [DW-1:0] SAT = DISTANCE_SATURATED[DW-1:0];

  logic [LANES-1:0][DW-1:0] lane_d;
  logic [LANES-1:0]         lane_en;
  logic                     accept, delim, step;

  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign delim         = accept && s_axis_tuser;
  assign step          = accept && !s_axis_tuser;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    levenshtein_lane #(
      .BITVECTOR_WIDTH (BITVECTOR_WIDTH),
      .DISTANCE_WIDTH  (DISTANCE_WIDTH)
    ) u_lane (
      .aclk      (aclk),
      .areset    (areset),
      .init      (delim),
      .step      (step),
      .pm        (s_axis_tdata[k*BITVECTOR_WIDTH +: BITVECTOR_WIDTH]),
      .word_size (word_size[k*DW +: DW]),
      .d         (lane_d[k]),
      .en        (lane_en[k])
    );
  end

  // Strict less-than keeps the lowest lane on ties.
  logic [DW-1:0]               best_d;
  logic [LANE_INDEX_WIDTH-1:0] best_id;
  logic                        any_en;
  logic [LANES-1:0]            match_vec;

  always_comb begin
    best_d    = SAT;
    best_id   = '0;
    any_en    = 1'b0;
    match_vec = '0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_en[k] && (!any_en || lane_d[k] < best_d)) begin
        best_d  = lane_d[k];
        best_id = LANE_INDEX_WIDTH'(k);
        any_en  = 1'b1;
      end
      match_vec[k] = lane_en[k] && (lane_d[k] <= threshold);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tid    <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (m_axis_tready) m_axis_tvalid <= 1'b0;
      if (delim) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= best_d;
        m_axis_tid    <= best_id;
        m_axis_tuser  <= any_en && (best_d <= threshold);
        m_axis_tlast  <= s_axis_tlast;
      end
    end
  end

`ifdef LEVENSHTEIN_MATCH_VECTOR_EN
  always_ff @(posedge aclk) begin
    if (areset)     m_axis_tmatch <= '0;
    else if (delim) m_axis_tmatch <= match_vec;
  end
`else
  logic unused_match;
  assign unused_match = ^match_vec;
`endif

endmodule

// File: tb/tb_levenshtein_multi.sv
// Directed bench for levenshtein_multi: 2 lanes, 8-bit pattern vectors, 4-bit distances.
module tb_levenshtein_multi;

  logic        aclk = 1'b0;
  logic        areset;
  logic [7:0]  word_size;
  logic [3:0]  threshold;
  logic        s_tvalid, s_tready, s_tuser, s_tlast;
  logic [15:0] s_tdata;
  logic        m_tvalid, m_tready, m_tuser, m_tlast;
  logic [3:0]  m_tdata;
  logic        m_tid;
`ifdef LEVENSHTEIN_MATCH_VECTOR_EN
  logic [1:0]  m_tmatch;
`endif

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  levenshtein_multi #(
    .BITVECTOR_WIDTH  (8),
    .DISTANCE_WIDTH   (4),
    .LANES            (2),
    .LANE_INDEX_WIDTH (1)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .word_size     (word_size),
    .threshold     (threshold),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tuser  (s_tuser),
    .s_axis_tlast  (s_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tid    (m_tid),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast)
`ifdef LEVENSHTEIN_MATCH_VECTOR_EN
    ,
    .m_axis_tmatch (m_tmatch)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic user, input logic last, input logic [7:0] pm0, input logic [7:0] pm1);
    int n;
    s_tvalid = 1'b1; s_tuser = user; s_tlast = last; s_tdata = {pm1, pm0};
    n = 0;
    while (!s_tready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    chk("accept_in_budget", 32'(n < 50), 32'd1);
    @(negedge aclk);
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; s_tdata = '0;
  endtask

  task automatic chk_res(input string tag, input logic [3:0] d, input logic id,
                         input logic user, input logic last);
    chk({tag, "_tvalid"}, 32'(m_tvalid), 32'd1);
    chk({tag, "_tdata"},  32'(m_tdata),  32'(d));
    chk({tag, "_tid"},    32'(m_tid),    32'(id));
    chk({tag, "_tuser"},  32'(m_tuser),  32'(user));
    chk({tag, "_tlast"},  32'(m_tlast),  32'(last));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1; m_tready = 1'b1; word_size = {4'd3, 4'd3}; threshold = 4'd1;
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; s_tdata = '0;
    repeat (2) @(negedge aclk);
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tdata",  32'(m_tdata),  32'd0);
    chk("rst_tid",    32'(m_tid),    32'd0);
    chk("rst_tuser",  32'(m_tuser),  32'd0);
    chk("rst_tlast",  32'(m_tlast),  32'd0);
    areset = 1'b0;
    chk("rst_sready", 32'(s_tready), 32'd1);

    // Lane0 "abc" vs text "abc" -> 0; lane1 "xyz" -> 3.
    send(1'b0, 1'b0, 8'b001, 8'b0);
    send(1'b0, 1'b0, 8'b010, 8'b0);
    send(1'b0, 1'b0, 8'b100, 8'b0);
    chk("t1_pre_tvalid", 32'(m_tvalid), 32'd0);
    send(1'b1, 1'b1, 8'b0, 8'b0);
    chk_res("t1", 4'd0, 1'b0, 1'b1, 1'b1);
    @(negedge aclk);
    chk("t1_single_pulse", 32'(m_tvalid), 32'd0);

    // Both lanes "abc" vs "abd" -> 1 each; tie to lane 0; 1 > threshold 0.
    threshold = 4'd0;
    send(1'b0, 1'b0, 8'b001, 8'b001);
    send(1'b0, 1'b0, 8'b010, 8'b010);
    send(1'b0, 1'b0, 8'b000, 8'b000);
    send(1'b1, 1'b0, 8'b0, 8'b0);
    chk_res("t2", 4'd1, 1'b0, 1'b0, 1'b0);

    // Backpressure: "abc" vs "a?" -> 2, "xyz" vs "??" -> 3; then an empty word.
    threshold = 4'd2;
    send(1'b0, 1'b0, 8'b001, 8'b000);
    send(1'b0, 1'b0, 8'b000, 8'b000);
    word_size = {4'd4, 4'd5};
    m_tready = 1'b0;
    send(1'b1, 1'b0, 8'b0, 8'b0);
    chk_res("t3_first", 4'd2, 1'b0, 1'b1, 1'b0);
    threshold = 4'd3;
    s_tvalid = 1'b1; s_tuser = 1'b1; s_tlast = 1'b1;
    @(negedge aclk);
    chk("t3_sready_low", 32'(s_tready), 32'd0);
    repeat (3) @(negedge aclk);
    chk_res("t3_hold", 4'd2, 1'b0, 1'b1, 1'b0);
    chk("t3_sready_still_low", 32'(s_tready), 32'd0);
    m_tready = 1'b1;
    @(negedge aclk);
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    chk_res("t3_second", 4'd4, 1'b1, 1'b0, 1'b1);
    @(negedge aclk);
    chk("t3_one_result", 32'(m_tvalid), 32'd0);

    // Empty words and lane disable (ws 0).
    word_size = {4'd5, 4'd0};
    threshold = 4'd5;
    send(1'b1, 1'b0, 8'b0, 8'b0);
    chk_res("t4_prev", 4'd4, 1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b0, 8'b0, 8'b0);
    chk_res("t4_empty", 4'd5, 1'b1, 1'b1, 1'b0);
    word_size = {4'd0, 4'd0};
    threshold = 4'd15;
    send(1'b1, 1'b0, 8'b0, 8'b0);
    send(1'b1, 1'b0, 8'b0, 8'b0);
    chk_res("t4_none", 4'd15, 1'b0, 1'b0, 1'b0);

    // Saturation: lane0 ws 1 with 20 misses; lane1 ws 9 exceeds width -> disabled.
    word_size = {4'd9, 4'd1};
    threshold = 4'd3;
    send(1'b1, 1'b0, 8'b0, 8'b0);
    chk_res("t5_prev", 4'd15, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) send(1'b0, 1'b0, 8'b0, 8'hFF);
    chk("t5_ovf_set", 32'(dut.g_lane[0].u_lane.ovf), 32'd1);
    send(1'b1, 1'b1, 8'b0, 8'b0);
    chk_res("t5_sat", 4'd15, 1'b0, 1'b0, 1'b1);
    chk("t5_ovf_clear", 32'(dut.g_lane[0].u_lane.ovf), 32'd0);
    send(1'b0, 1'b0, 8'b1, 8'b0);
    send(1'b1, 1'b0, 8'b0, 8'b0);
    chk_res("t5_clean", 4'd0, 1'b0, 1'b1, 1'b0);

    // Reset discards a pending result and a partial word, and beats the same-cycle delimiter.
    word_size = {4'd3, 4'd3};
    threshold = 4'd1;
    m_tready = 1'b0;
    send(1'b1, 1'b0, 8'b0, 8'b0);
    chk("t6_pending", 32'(m_tvalid), 32'd1);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    chk("t6_pending_dropped", 32'(m_tvalid), 32'd0);
    m_tready = 1'b1;
    send(1'b0, 1'b0, 8'b100, 8'b0);
    send(1'b0, 1'b0, 8'b100, 8'b0);
    areset = 1'b1; s_tvalid = 1'b1; s_tuser = 1'b1;
    @(negedge aclk);
    areset = 1'b0; s_tvalid = 1'b0; s_tuser = 1'b0;
    chk("t6_rst_tvalid", 32'(m_tvalid), 32'd0);
    @(negedge aclk);
    chk("t6_rst_tvalid_after", 32'(m_tvalid), 32'd0);
    send(1'b0, 1'b0, 8'b001, 8'b0);
    send(1'b0, 1'b0, 8'b010, 8'b0);
    send(1'b0, 1'b0, 8'b100, 8'b0);
    send(1'b1, 1'b1, 8'b0, 8'b0);
    chk_res("t6_fresh", 4'd0, 1'b0, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
